// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one pending result per cycle (round-robin when CDB_ROUND_ROBIN_EN is defined, else lowest index);
// the winner is broadcast on the cdb_* registers one cycle later; rdy_in=0 freezes all state and withholds grants.
`ifndef ROB_BIT
`define ROB_BIT 4
`endif

module cdb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int SRC_W   = 2
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        clear_up,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*`ROB_BIT-1:0] req_rob_entry,
   input  logic [NUM_REQ*DATA_W-1:0]   req_value,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        cdb_valid,
   output logic [`ROB_BIT-1:0]         cdb_rob_entry,
   output logic [DATA_W-1:0]           cdb_value,
   output logic [SRC_W-1:0]            cdb_src
);

   logic [`ROB_BIT-1:0] rob_arr [NUM_REQ];
   logic [DATA_W-1:0]   val_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign rob_arr[g] = req_rob_entry[g*`ROB_BIT +: `ROB_BIT];
      assign val_arr[g] = req_value[g*DATA_W +: DATA_W];
   end

   logic [SRC_W-1:0]    last_q, last_d;
   logic                cdb_valid_q, cdb_valid_d;
   logic [`ROB_BIT-1:0] cdb_rob_q, cdb_rob_d;
   logic [DATA_W-1:0]   cdb_value_q, cdb_value_d;
   logic [SRC_W-1:0]    cdb_src_q, cdb_src_d;

   logic                grant_found;
   logic [SRC_W-1:0]    grant_idx;
   logic [SRC_W-1:0]    cand;
   logic                active;

   // Winner search; the fixed-priority build still tracks last_q but never reads it here.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
`ifdef CDB_ROUND_ROBIN_EN
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = SRC_W'((int'(last_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
`else
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = SRC_W'(k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
`endif
   end

   assign active = rdy_in && !clear_up && !rst_in;

   always_comb begin
      req_ready = '0;
      if (active && grant_found)
         req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      last_d      = last_q;
      cdb_valid_d = cdb_valid_q;
      cdb_rob_d   = cdb_rob_q;
      cdb_value_d = cdb_value_q;
      cdb_src_d   = cdb_src_q;
      if (rdy_in) begin
         if (clear_up) begin
            cdb_valid_d = 1'b0;
            last_d      = SRC_W'(NUM_REQ - 1);
         end else if (grant_found) begin
            cdb_valid_d = 1'b1;
            last_d      = grant_idx;
            cdb_rob_d   = rob_arr[grant_idx];
            cdb_value_d = val_arr[grant_idx];
            cdb_src_d   = grant_idx;
         end else begin
            cdb_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_q      <= SRC_W'(NUM_REQ - 1);
         cdb_valid_q <= 1'b0;
         cdb_rob_q   <= '0;
         cdb_value_q <= '0;
         cdb_src_q   <= '0;
      end else begin
         last_q      <= last_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_rob_q   <= cdb_rob_d;
         cdb_value_q <= cdb_value_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdb_valid     = cdb_valid_q;
   assign cdb_rob_entry = cdb_rob_q;
   assign cdb_value     = cdb_value_q;
   assign cdb_src       = cdb_src_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk_in) begin
      if (active && grant_found)
         assert (req_valid[grant_idx]) else $error("cdb_arbiter: grant to idle requester");
   end
`endif

endmodule
